fp_multiplier_seq: RTL and testbench

- Iterative single-precision IEEE-754 multiplier. It is the inverse operation of the existing fp_divider and sits beside it in the FP datapath.
- Operands are captured on a start handshake. The 24x24 mantissa product is formed by shift-add, one bit per clock.
- The block then normalises the product, packs the result and pulses done. Special operands bypass the iterative datapath.

---
 rtl/fp_multiplier_seq.sv | 154 +++++++++++++++
 tb/tb_fp_multiplier_seq.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/fp_multiplier_seq.sv
// Iterative IEEE-754 single-precision multiplier: shift-add mantissa product, one bit per clock,
// then a single normalise/pack cycle. Special operands skip the iterative datapath.
module fp_multiplier_seq #(
  parameter int unsigned MANT_W   = 24,
  parameter int unsigned EXP_BIAS = 127
) (
  input  logic        int_clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [31:0] Out,
  output logic        busy,
  output logic        done
);

  localparam int unsigned ProdW = 2 * MANT_W;
  localparam int unsigned CntW  = $clog2(MANT_W);

  typedef enum logic [1:0] {StIdle, StMult, StNorm} state_e;

  state_e             state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [ProdW-1:0]   mcand_q, mcand_d;
  logic [MANT_W-1:0]  mplier_q, mplier_d;
  logic [ProdW-1:0]   acc_q, acc_d;
  logic signed [9:0]  exp_q, exp_d;
  logic               sign_q, sign_d;
  logic               special_q, special_d;
  logic [31:0]        spec_res_q, spec_res_d;
  logic [31:0]        out_q, out_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  // Operand classification for the bypass path; exp=0 (zero or denormal) counts as zero.
  logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, in_sign;
  logic in_special;
  logic [31:0] in_spec_res;

  always_comb begin
    a_nan   = (&A[30:23]) && (|A[22:0]);
    b_nan   = (&B[30:23]) && (|B[22:0]);
    a_inf   = (&A[30:23]) && ~(|A[22:0]);
    b_inf   = (&B[30:23]) && ~(|B[22:0]);
    a_zero  = ~(|A[30:23]);
    b_zero  = ~(|B[30:23]);
    in_sign = A[31] ^ B[31];
    in_special  = 1'b1;
    in_spec_res = 32'h0;
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
      in_spec_res = 32'h7FC0_0000;
    end else if (a_inf || b_inf) begin
      in_spec_res = {in_sign, 8'hFF, 23'h0};
    end else if (a_zero || b_zero) begin
      in_spec_res = {in_sign, 31'h0};
    end else begin
      in_special = 1'b0;
    end
  end

  logic signed [9:0] exp_fin;
  logic [22:0]       frac_fin;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    mcand_d    = mcand_q;
    mplier_d   = mplier_q;
    acc_d      = acc_q;
    exp_d      = exp_q;
    sign_d     = sign_q;
    special_d  = special_q;
    spec_res_d = spec_res_q;
    out_d      = out_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    exp_fin    = exp_q + {9'd0, acc_q[ProdW-1]};
    frac_fin   = acc_q[ProdW-1] ? acc_q[ProdW-2 -: 23] : acc_q[ProdW-3 -: 23];

    unique case (state_q)
      StIdle: begin
        if (start) begin
          mcand_d    = ProdW'({1'b1, A[22:0]});
          mplier_d   = MANT_W'({1'b1, B[22:0]});
          acc_d      = '0;
          cnt_d      = '0;
          exp_d      = 10'(A[30:23]) + 10'(B[30:23]) - 10'(EXP_BIAS);
          sign_d     = in_sign;
          special_d  = in_special;
          spec_res_d = in_spec_res;
          busy_d     = 1'b1;
          state_d    = in_special ? StNorm : StMult;
        end
      end
      StMult: begin
        if (mplier_q[0]) acc_d = acc_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CntW'(MANT_W - 1)) state_d = StNorm;
      end
      StNorm: begin
        if (special_q) begin
          out_d = spec_res_q;
        end else if (exp_fin >= 10'sd255) begin
          out_d = {sign_q, 8'hFF, 23'h0};
        end else if (exp_fin <= 10'sd0) begin
          out_d = {sign_q, 31'h0};
        end else begin
          out_d = {sign_q, exp_fin[7:0], frac_fin};
        end
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge int_clk) begin
    if (reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      mcand_q    <= '0;
      mplier_q   <= '0;
      acc_q      <= '0;
      exp_q      <= '0;
      sign_q     <= 1'b0;
      special_q  <= 1'b0;
      spec_res_q <= '0;
      out_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      mcand_q    <= mcand_d;
      mplier_q   <= mplier_d;
      acc_q      <= acc_d;
      exp_q      <= exp_d;
      sign_q     <= sign_d;
      special_q  <= special_d;
      spec_res_q <= spec_res_d;
      out_q      <= out_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign Out  = out_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_fp_multiplier_seq.sv
// Bench for fp_multiplier_seq: directed cases plus random operands against a behavioural model.
module tb_fp_multiplier_seq;

  logic        int_clk = 1'b0;
  logic        reset   = 1'b1;
  logic        start   = 1'b0;
  logic [31:0] a       = '0;
  logic [31:0] b       = '0;
  logic [31:0] out;
  logic        busy;
  logic        done;

  int n_checks = 0;
  int n_fail   = 0;

  fp_multiplier_seq #(.MANT_W(24), .EXP_BIAS(127)) dut (
    .int_clk (int_clk),
    .reset   (reset),
    .start   (start),
    .A       (a),
    .B       (b),
    .Out     (out),
    .busy    (busy),
    .done    (done)
  );

  always #5 int_clk = ~int_clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic bit ref_special(input logic [31:0] x, input logic [31:0] y);
    return (x[30:23] == 8'h00) || (x[30:23] == 8'hFF) || (y[30:23] == 8'h00) ||
           (y[30:23] == 8'hFF);
  endfunction

  function automatic logic [31:0] ref_mul(input logic [31:0] x, input logic [31:0] y);
    int ex, ey, e;
    bit s, x_nan, y_nan, x_inf, y_inf;
    longint unsigned p;
    logic [22:0] frac;
    ex = int'(x[30:23]);
    ey = int'(y[30:23]);
    s  = x[31] ^ y[31];
    x_nan = (ex == 255) && (x[22:0] != 0);
    y_nan = (ey == 255) && (y[22:0] != 0);
    x_inf = (ex == 255) && (x[22:0] == 0);
    y_inf = (ey == 255) && (y[22:0] == 0);
    if (x_nan || y_nan || (x_inf && ey == 0) || (y_inf && ex == 0)) return 32'h7FC0_0000;
    if (x_inf || y_inf) return {s, 8'hFF, 23'h0};
    if (ex == 0 || ey == 0) return {s, 31'h0};
    p = (longint'(x[22:0]) + 64'd8388608) * (longint'(y[22:0]) + 64'd8388608);
    e = ex + ey - 127;
    if (p >= (64'd1 << 47)) begin
      e++;
      frac = 23'(p >> 24);
    end else begin
      frac = 23'(p >> 23);
    end
    if (e >= 255) return {s, 8'hFF, 23'h0};
    if (e <= 0) return {s, 31'h0};
    return {s, 8'(e), frac};
  endfunction

  // Called #1 after an edge; drives operands and holds start across exactly one edge.
  task automatic launch(input logic [31:0] x, input logic [31:0] y);
    a = x;
    b = y;
    start = 1'b1;
    @(posedge int_clk);
    #1;
    start = 1'b0;
  endtask

  // Waits (bounded) for done after an accepting edge; returns the edge count, accept = 1.
  task automatic wait_done(output int edges);
    edges = 1;
    while (!done && edges < 60) begin
      @(posedge int_clk);
      #1;
      edges++;
    end
  endtask

  task automatic run_op(input string tag, input logic [31:0] x, input logic [31:0] y);
    int edges;
    launch(x, y);
    check_eq({tag, " busy"}, 32'(busy), 32'd1);
    wait_done(edges);
    check_eq({tag, " latency"}, edges, ref_special(x, y) ? 32'd2 : 32'd26);
    check_eq({tag, " out"}, out, ref_mul(x, y));
    check_eq({tag, " busy_at_done"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int edges;
    int n_done;
    logic [31:0] x, y;

    repeat (3) @(posedge int_clk);
    #1;
    check_eq("reset out", out, 32'h0);
    check_eq("reset busy", 32'(busy), 32'd0);
    check_eq("reset done", 32'(done), 32'd0);
    reset = 1'b0;
    @(posedge int_clk);
    #1;

    // 8 x 2 with done pulse width check
    run_op("t1", 32'h4100_0000, 32'h4000_0000);
    check_eq("t1 const", out, 32'h4180_0000);
    @(posedge int_clk);
    #1;
    check_eq("t1 done_width", 32'(done), 32'd0);

    run_op("t2", 32'h3FC0_0000, 32'h3FC0_0000);
    check_eq("t2 const", out, 32'h4010_0000);
    run_op("t3a", 32'hBFC0_0000, 32'h4020_0000);
    check_eq("t3a const", out, 32'hC070_0000);
    run_op("t3b", 32'hBFC0_0000, 32'hC020_0000);
    check_eq("t3b const", out, 32'h4070_0000);
    run_op("t4a", 32'h0000_0000, 32'hC0A0_0000);
    check_eq("t4a const", out, 32'h8000_0000);
    run_op("t4b", 32'h7F80_0000, 32'h0000_0000);
    check_eq("t4b const", out, 32'h7FC0_0000);
    run_op("t5a", 32'h7F00_0000, 32'h7F00_0000);
    check_eq("t5a const", out, 32'h7F80_0000);
    run_op("t5b", 32'h0080_0000, 32'h0080_0000);
    check_eq("t5b const", out, 32'h0000_0000);

    // start while busy at edge 5 must be ignored
    launch(32'h4100_0000, 32'h4000_0000);
    repeat (3) @(posedge int_clk);
    #1;
    a = 32'h4040_0000;
    b = 32'h4040_0000;
    start = 1'b1;
    @(posedge int_clk);
    #1;
    start = 1'b0;
    edges = 5;
    while (!done && edges < 60) begin
      @(posedge int_clk);
      #1;
      edges++;
    end
    check_eq("t6 ignore latency", edges, 32'd26);
    check_eq("t6 ignore out", out, 32'h4180_0000);

    // reset at edge 10 aborts; no done afterwards
    @(posedge int_clk);
    #1;
    launch(32'h4100_0000, 32'h4000_0000);
    repeat (8) @(posedge int_clk);
    #1;
    reset = 1'b1;
    @(posedge int_clk);
    #1;
    reset = 1'b0;
    check_eq("t6 abort busy", 32'(busy), 32'd0);
    check_eq("t6 abort out", out, 32'h0);
    n_done = 0;
    repeat (40) begin
      @(posedge int_clk);
      #1;
      if (done) n_done++;
    end
    check_eq("t6 abort no_done", n_done, 32'd0);

    // back-to-back: start issued in the done cycle
    run_op("t6 b2b_first", 32'h3FC0_0000, 32'h4000_0000);
    check_eq("t6 b2b_in_done", 32'(done), 32'd1);
    run_op("t6 b2b_second", 32'hC000_0000, 32'h4040_0000);
    check_eq("t6 b2b_const", out, 32'hC0C0_0000);

    for (int i = 0; i < 40; i++) begin
      x = $urandom;
      y = $urandom;
      if ($urandom_range(0, 3) != 0) x[30:23] = 8'($urandom_range(64, 190));
      if ($urandom_range(0, 3) != 0) y[30:23] = 8'($urandom_range(64, 190));
      if ($urandom_range(0, 9) == 0) x[30:23] = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'hFF;
      if ($urandom_range(0, 15) == 0) y[22:0] = '0;
      run_op($sformatf("rnd%0d", i), x, y);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
